// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath widths, the PC step and the fetch FSM encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_INCR = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    // Instructions are 4-byte aligned; any low address bit set is a fault.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Valid/ready handshake carrying one fetched instruction and its PC towards decode.
interface instruction_fetch_if;
    import riscv_pkg::*;

    logic            fetch_valid;
    logic            fetch_ready;
    logic [ILEN-1:0] fetch_instr;
    logic [XLEN-1:0] fetch_pc;

    modport master (
        output fetch_valid,
        output fetch_instr,
        output fetch_pc,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_instr,
        input  fetch_pc,
        output fetch_ready
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with redirect / sequential / hold selection and target alignment check.
module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            target_misaligned
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect outranks sequential advance; the sum wraps naturally at 2^XLEN.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (advance) begin
            pc_d = pc_q + PC_INCR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc                = pc_q;
    assign target_misaligned = is_misaligned(redirect_pc);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage top: sequencing FSM, decode-facing output register and accepted-transfer counter.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [3:0][7:0]     imem_instr,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    instruction_fetch_if.master fetch,
    output logic                fetch_misaligned,
    output logic [XLEN-1:0]     fetch_count
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic            valid_q;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] out_pc_q;
    logic [XLEN-1:0] count_q;
    logic [XLEN-1:0] pc;
    logic            target_misaligned;
    logic            redirect_take;
    logic            capture;
    logic            transfer;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk               (clk),
        .rst               (rst),
        .redirect          (redirect_take),
        .redirect_pc       (redirect_pc),
        .advance           (capture),
        .pc                (pc),
        .target_misaligned (target_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        redirect_take = 1'b0;
        capture       = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    redirect_take = 1'b1;
                    state_d       = target_misaligned ? HALT : RUN;
                end else begin
                    // Refill whenever the register is empty or being drained this cycle.
                    capture = !valid_q || fetch.fetch_ready;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    redirect_take = 1'b1;
                    state_d       = target_misaligned ? HALT : RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A redirect squashes the held entry, so it is never counted as a transfer.
    assign transfer = valid_q && fetch.fetch_ready && !redirect_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            out_pc_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_take) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                valid_q  <= 1'b1;
                instr_q  <= {imem_instr[3], imem_instr[2], imem_instr[1], imem_instr[0]};
                out_pc_q <= pc;
            end else if (transfer) begin
                valid_q <= 1'b0;
            end
            if (transfer) begin
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    assign imem_addr         = pc;
    assign fetch.fetch_valid = valid_q;
    assign fetch.fetch_instr = instr_q;
    assign fetch.fetch_pc    = out_pc_q;
    assign fetch_misaligned  = (state_q == HALT);
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized stream scoreboard.
module tb_instruction_fetch;
    import riscv_pkg::*;

    localparam logic [XLEN-1:0] RST_PC = 64'h1000;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] imem_addr;
    logic [3:0][7:0] imem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_misaligned;
    logic [XLEN-1:0] fetch_count;
    logic            byte_mode;

    int n_vec;
    int n_err;

    instruction_fetch_if fif ();

    instruction_fetch #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_instr       (imem_instr),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch            (fif),
        .fetch_misaligned (fetch_misaligned),
        .fetch_count      (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the address, so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    always_comb begin
        if (byte_mode) begin
            imem_instr[0] = 8'h13;
            imem_instr[1] = 8'h00;
            imem_instr[2] = 8'h00;
            imem_instr[3] = 8'h00;
        end else begin
            imem_instr = mem_word(imem_addr);
        end
    end

    task automatic apply_reset;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        fif.fetch_ready = 1'b1;
        apply_reset();
        n_vec++; if (imem_addr !== RST_PC) begin n_err++;
            $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
        n_vec++; if (fif.fetch_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid: got %b want 0", fif.fetch_valid); end
        n_vec++; if (fif.fetch_instr !== 32'h0) begin n_err++;
            $display("FAIL reset_instr: got %h want 0", fif.fetch_instr); end
        n_vec++; if (fif.fetch_pc !== 64'h0) begin n_err++;
            $display("FAIL reset_pc: got %h want 0", fif.fetch_pc); end
        n_vec++; if (fetch_misaligned !== 1'b0) begin n_err++;
            $display("FAIL reset_mis: got %b want 0", fetch_misaligned); end
        n_vec++; if (fetch_count !== 64'h0) begin n_err++;
            $display("FAIL reset_count: got %0d want 0", fetch_count); end
        @(negedge clk);
        n_vec++; if (fif.fetch_valid !== 1'b0 || imem_addr !== RST_PC) begin n_err++;
            $display("FAIL start_cycle: valid %b addr %h want 0 %h", fif.fetch_valid, imem_addr,
                     RST_PC); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== RST_PC + 64'(4 * k)) begin
                n_err++;
                $display("FAIL start_pc%0d: valid %b pc %h want 1 %h", k, fif.fetch_valid,
                         fif.fetch_pc, RST_PC + 64'(4 * k)); end
            n_vec++; if (fif.fetch_instr !== mem_word(RST_PC + 64'(4 * k))) begin n_err++;
                $display("FAIL start_instr%0d: got %h want %h", k, fif.fetch_instr,
                         mem_word(RST_PC + 64'(4 * k))); end
            n_vec++; if (imem_addr !== RST_PC + 64'(4 * k + 4)) begin n_err++;
                $display("FAIL start_addr%0d: got %h want %h", k, imem_addr,
                         RST_PC + 64'(4 * k + 4)); end
            n_vec++; if (fetch_count !== 64'(k)) begin n_err++;
                $display("FAIL start_count%0d: got %0d want %0d", k, fetch_count, k); end
        end
        @(negedge clk);
        n_vec++; if (fetch_count !== 64'd3) begin n_err++;
            $display("FAIL count_after3: got %0d want 3", fetch_count); end
    endtask

    task automatic test_backpressure;
        fif.fetch_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== 64'h100C ||
                         fif.fetch_instr !== mem_word(64'h100C)) begin n_err++;
                $display("FAIL stall_hold%0d: valid %b pc %h instr %h want 1 100c %h", k,
                         fif.fetch_valid, fif.fetch_pc, fif.fetch_instr, mem_word(64'h100C)); end
            n_vec++; if (imem_addr !== 64'h1010 || fetch_count !== 64'd3) begin n_err++;
                $display("FAIL stall_addr_cnt%0d: addr %h cnt %0d want 1010 3", k, imem_addr,
                         fetch_count); end
        end
        fif.fetch_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (fif.fetch_pc !== 64'h1010 || fetch_count !== 64'd4) begin n_err++;
            $display("FAIL stall_resume: pc %h cnt %0d want 1010 4", fif.fetch_pc, fetch_count); end
        @(negedge clk);
        n_vec++; if (fif.fetch_pc !== 64'h1014 || fetch_count !== 64'd5) begin n_err++;
            $display("FAIL stall_next: pc %h cnt %0d want 1014 5", fif.fetch_pc, fetch_count); end
    endtask

    task automatic test_redirect_transfer;
        fif.fetch_ready = 1'b1;
        apply_reset();
        repeat (4) @(negedge clk);
        n_vec++; if (fif.fetch_pc !== 64'h1008 || fetch_count !== 64'd2) begin n_err++;
            $display("FAIL redir_pre: pc %h cnt %0d want 1008 2", fif.fetch_pc, fetch_count); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++; if (fif.fetch_valid !== 1'b0 || fetch_count !== 64'd2 ||
                     imem_addr !== 64'h2000) begin n_err++;
            $display("FAIL redir_bubble: valid %b cnt %0d addr %h want 0 2 2000",
                     fif.fetch_valid, fetch_count, imem_addr); end
        @(negedge clk);
        n_vec++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== 64'h2000 ||
                     fetch_count !== 64'd2) begin n_err++;
            $display("FAIL redir_first: valid %b pc %h cnt %0d want 1 2000 2", fif.fetch_valid,
                     fif.fetch_pc, fetch_count); end
        @(negedge clk);
        n_vec++; if (fif.fetch_pc !== 64'h2004 || fetch_count !== 64'd3) begin n_err++;
            $display("FAIL redir_second: pc %h cnt %0d want 2004 3", fif.fetch_pc, fetch_count); end
    endtask

    task automatic test_misaligned;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2002;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (fetch_misaligned !== 1'b1 || fif.fetch_valid !== 1'b0 ||
                         imem_addr !== 64'h2002 || fetch_count !== 64'd3) begin n_err++;
                $display("FAIL halt%0d: mis %b valid %b addr %h cnt %0d want 1 0 2002 3", k,
                         fetch_misaligned, fif.fetch_valid, imem_addr, fetch_count); end
            @(negedge clk);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++; if (fetch_misaligned !== 1'b0 || fif.fetch_valid !== 1'b0 ||
                     imem_addr !== 64'h3000) begin n_err++;
            $display("FAIL unhalt: mis %b valid %b addr %h want 0 0 3000", fetch_misaligned,
                     fif.fetch_valid, imem_addr); end
        @(negedge clk);
        n_vec++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== 64'h3000) begin n_err++;
            $display("FAIL unhalt_pc: valid %b pc %h want 1 3000", fif.fetch_valid,
                     fif.fetch_pc); end
    endtask

    task automatic test_wrap;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_top: valid %b pc %h want 1 fffffffffffffffc", fif.fetch_valid,
                     fif.fetch_pc); end
        @(negedge clk);
        n_vec++; if (fif.fetch_pc !== 64'h0 || fetch_misaligned !== 1'b0 ||
                     fif.fetch_instr !== mem_word(64'h0)) begin n_err++;
            $display("FAIL wrap_zero: pc %h mis %b instr %h want 0 0 %h", fif.fetch_pc,
                     fetch_misaligned, fif.fetch_instr, mem_word(64'h0)); end
    endtask

    task automatic test_byte_order;
        byte_mode = 1'b1;
        @(negedge clk);
        byte_mode = 1'b0;
        n_vec++; if (fif.fetch_instr !== 32'h0000_0013) begin n_err++;
            $display("FAIL byte_order: got %h want 00000013", fif.fetch_instr); end
    endtask

    task automatic test_rst_redirect;
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5000;
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        n_vec++; if (imem_addr !== RST_PC || fif.fetch_valid !== 1'b0 ||
                     fetch_count !== 64'd0 || fetch_misaligned !== 1'b0) begin n_err++;
            $display("FAIL rst_wins: addr %h valid %b cnt %0d mis %b want %h 0 0 0", imem_addr,
                     fif.fetch_valid, fetch_count, fetch_misaligned, RST_PC); end
        repeat (2) @(negedge clk);
        n_vec++; if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== RST_PC) begin n_err++;
            $display("FAIL rst_restart: valid %b pc %h want 1 %h", fif.fetch_valid,
                     fif.fetch_pc, RST_PC); end
    endtask

    // Stream-level scoreboard: the accepted PCs form a +4 sequence that restarts at each aligned
    // redirect target after exactly one empty cycle; misaligned targets park the stage.
    task automatic test_random;
        logic [XLEN-1:0] exp_pc;
        logic [XLEN-1:0] halt_pc;
        logic [XLEN-1:0] cnt;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] exp_addr;
        bit              halted;
        bit              exp_v;
        int              bubble;
        fif.fetch_ready = 1'b1;
        apply_reset();
        exp_pc  = RST_PC;
        halt_pc = '0;
        cnt     = '0;
        halted  = 1'b0;
        bubble  = 2;
        for (int c = 0; c < 600; c++) begin
            exp_v    = !halted && (bubble == 0);
            exp_addr = halted ? halt_pc : (exp_v ? exp_pc + 64'd4 : exp_pc);
            n_vec++; if (fif.fetch_valid !== exp_v || fetch_misaligned !== halted) begin n_err++;
                $display("FAIL rnd_flags c%0d: valid %b mis %b want %b %b", c, fif.fetch_valid,
                         fetch_misaligned, exp_v, halted); end
            n_vec++; if (imem_addr !== exp_addr || fetch_count !== cnt) begin n_err++;
                $display("FAIL rnd_addr_cnt c%0d: addr %h cnt %0d want %h %0d", c, imem_addr,
                         fetch_count, exp_addr, cnt); end
            if (exp_v) begin
                n_vec++; if (fif.fetch_pc !== exp_pc || fif.fetch_instr !== mem_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL rnd_data c%0d: pc %h instr %h want %h %h", c, fif.fetch_pc,
                             fif.fetch_instr, exp_pc, mem_word(exp_pc)); end
            end
            fif.fetch_ready = ($urandom_range(0, 3) != 0);
            redirect_valid  = (bubble != 2) && ($urandom_range(0, 9) == 0);
            tgt             = {$urandom(), $urandom()};
            if ($urandom_range(0, 4) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt[63:8] = '1;
            redirect_pc = tgt;
            if (bubble > 0) bubble--;
            if (redirect_valid) begin
                if (tgt[1:0] != 2'b00) begin
                    halted  = 1'b1;
                    halt_pc = tgt;
                end else begin
                    halted = 1'b0;
                    exp_pc = tgt;
                    bubble = 1;
                end
            end else if (exp_v && fif.fetch_ready) begin
                cnt    = cnt + 64'd1;
                exp_pc = exp_pc + 64'd4;
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        byte_mode       = 1'b0;
        fif.fetch_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_backpressure();
        test_redirect_transfer();
        test_misaligned();
        test_wrap();
        test_byte_order();
        test_rst_redirect();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage that owns the program counter, drives the read address of the instruction memory, and hands each returned 32-bit instruction together with its PC to decode through a valid/ready handshake. It sits directly upstream of the instruction memory's address port and directly downstream of its instruction output. It also accepts branch/jump redirects from execute and halts on misaligned targets.

## Interface
- XLEN, 64, address and PC width
- ILEN, 32, instruction width in bits (4 bytes)
- RESET_PC, 0, PC loaded on reset
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_addr  output  XLEN  byte address to instruction memory; equals pc
- imem_instr  input  [3:0][7:0]  instruction bytes at imem_addr; byte 0 is at imem_addr, combinational return
- redirect_valid  input  1  execute requests a PC change this cycle
- redirect_pc  input  XLEN  redirect target
- fetch_valid  output  1  fetch_instr/fetch_pc hold a valid instruction
- fetch_ready  input  1  decode accepts this cycle
- fetch_instr  output  ILEN  {imem_instr[3], imem_instr[2], imem_instr[1], imem_instr[0]}
- fetch_pc  output  XLEN  PC of fetch_instr
- fetch_misaligned  output  1  fetch halted on a target with pc[1:0] != 0
- fetch_count  output  XLEN  number of accepted handshakes since reset

## Operation
- States: IDLE, RUN, HALT.
- IDLE: entered on reset. pc = RESET_PC. No capture. Next cycle: RUN.
- RUN: when the output register is empty or fetch_ready = 1, capture imem_instr and pc into the output register, set fetch_valid, and set pc <= pc + 4. Otherwise hold pc and the output register.
- Redirect, any state except IDLE, highest priority: pc <= redirect_pc and fetch_valid <= 0. The instruction held in the output register is discarded even if fetch_ready = 1 in the same cycle; fetch_count does not increment. If redirect_pc[1:0] != 0, the next state is HALT. Otherwise it is RUN.
- HALT: fetch_misaligned = 1, fetch_valid = 0, pc frozen, no captures. Exit only via a redirect with aligned target (-> RUN) or rst.
- Handshake: a transfer occurs when fetch_valid & fetch_ready. While fetch_valid = 1 and fetch_ready = 0, fetch_instr and fetch_pc are stable. fetch_valid drops only on transfer with no refill, on redirect, or on rst.
- fetch_count increments by 1 per transfer and wraps modulo 2^XLEN.
- PC arithmetic is modulo 2^XLEN: pc = 2^XLEN - 4 advances to 0 with no fault.

## Timing
- Reset values: imem_addr = RESET_PC, fetch_valid = 0, fetch_instr = 0, fetch_pc = 0, fetch_misaligned = 0, fetch_count = 0, state IDLE.
- Latency: the instruction at pc appears on fetch_* one cycle after pc is driven on imem_addr.
- First valid output: RESET_PC's instruction is valid 2 cycles after rst deasserts (IDLE cycle plus capture cycle).
- Throughput: 1 instruction per cycle while fetch_ready = 1.
- Redirect in cycle N: imem_addr = redirect_pc in N+1, instruction valid in N+2. This gives a 1-cycle bubble.
- Redirect and rst together: rst wins.
- Redirect while stalled (fetch_valid = 1, fetch_ready = 0): the held entry is dropped and the new stream starts as above.
- rst mid-stream: all state returns to reset values on the next edge regardless of handshake.

## Structure
- Shared package riscv_pkg: XLEN, ILEN, the fetch_state_t enum (IDLE, RUN, HALT), and the PC increment constant 4.
- One natural sub-module, fetch_pc_gen: holds the PC register, next-PC mux (redirect / pc+4 / hold), and the alignment check. The top level holds the FSM, output register and counter.

## Test plan
- Reset release with RESET_PC = 0x1000 and fetch_ready = 1 -> imem_addr 0x1000, 0x1004, 0x1008 on successive cycles; fetch_pc 0x1000 with its instruction valid 2 cycles after reset; fetch_count = 3 after three transfers.
- Back-pressure: hold fetch_ready = 0 for 3 cycles with fetch_valid = 1 -> fetch_pc, fetch_instr and imem_addr stable; fetch_count unchanged; stream resumes in order on release.
- Redirect to 0x2000 in the same cycle as a transfer of 0x1008 -> 0x1008 not counted; fetch_valid = 0 for 1 cycle; next fetch_pc = 0x2000.
- Redirect to 0x2002 -> fetch_misaligned = 1, fetch_valid = 0 indefinitely. A later redirect to 0x3000 clears the fault; fetch_pc = 0x3000 two cycles later.
- Wrap-around: redirect to 2^XLEN - 4 -> fetch_pc = 0xFFFF_FFFF_FFFF_FFFC, then 0x0, with no fault.
- Byte order: imem_instr bytes {0x13, 0x00, 0x00, 0x00} (byte 0 = 0x13) -> fetch_instr = 0x00000013.
